// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce_pkg
//  Purpose  : Shared types for the switch debouncer. Holds the per-bit
//             debounce state encoding used by debounce_bit.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package switch_debounce_pkg;

    // Per-bit debounce state: idle with the input agreeing with the
    // debounced level, or counting towards a level flip.
    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

endpackage : switch_debounce_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_bit
//  Purpose  : One-bit switch conditioner: 2-flop synchronizer, stability
//             counter, debounced level register and registered rise/fall
//             pulses.
//  Ports    : clk      - clock, all state on rising edge
//             reset    - synchronous active-high reset
//             s_i      - raw asynchronous switch level
//             level_o  - debounced level (registered)
//             rise_o   - one-cycle 0->1 pulse (registered)
//             fall_o   - one-cycle 1->0 pulse (registered)
//             flip_o   - level will flip on the next edge (combinational,
//                        lets the parent register a coincident summary flag)
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter int CW            = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic s_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic flip_o
);

    localparam logic [CW-1:0] C_TERM = CW'(STABLE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    db_state_e     state_q;
    logic          flip_d;

    // Terminal count reached while the synchronized input still disagrees
    // with the debounced level: the level flips on the coming edge.
    assign flip_d = (state_q == ST_COUNTING) && (cnt_q == C_TERM) &&
                    (sync2_q != level_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
        end else begin
            sync1_q <= s_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                // Any bounce back to the current level discards the count.
                cnt_q   <= '0;
                state_q <= ST_STABLE;
            end else if (flip_d) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
                state_q <= ST_STABLE;
            end else begin
                cnt_q   <= cnt_q + CW'(1);
                state_q <= ST_COUNTING;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign flip_o  = flip_d;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debounce
//  Purpose  : Conditions N raw board switches/buttons into clean debounced
//             levels with one-cycle rise/fall pulses per bit.
//  Ports    : clk     - clock
//             reset   - synchronous active-high reset
//             s       - raw switch levels [N-1:0], asynchronous to clk
//             s_db    - debounced levels (registered)
//             rise    - per-bit 0->1 pulses (registered)
//             fall    - per-bit 1->0 pulses (registered)
//             changed - OR of all rise|fall, registered, coincident
//  Revision : 1.0 - initial release
// ============================================================================
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int CW            = $clog2(STABLE_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] s,
    output logic [N-1:0] s_db,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         changed
);

    logic [N-1:0] flip_d;
    logic         changed_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CW            (CW)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .s_i     (s[gi]),
            .level_o (s_db[gi]),
            .rise_o  (rise[gi]),
            .fall_o  (fall[gi]),
            .flip_o  (flip_d[gi])
        );
    end

    // Registered from the per-bit flip indications so it lands in the same
    // cycle as the rise/fall pulses rather than one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |flip_d;
        end
    end

    assign changed = changed_q;

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debounce
//  Purpose  : Self-checking bench for switch_debounce (N=4, STABLE_CYCLES=4).
//             The driver issues one input vector per clock and queues the
//             hand-computed outputs expected right after that edge; a
//             separate monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] s;
    logic [3:0] s_db;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    typedef struct {
        string      name;
        logic [3:0] db;
        logic [3:0] rs;
        logic [3:0] fl;
        logic       chg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    switch_debounce #(
        .N             (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .s_db    (s_db),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle and queue what the outputs must be after that edge.
    task automatic step(input string name, input logic rv, input logic [3:0] sv,
                        input logic [3:0] edb, input logic [3:0] ers,
                        input logic [3:0] efl, input logic echg);
        exp_t e;
        reset = rv;
        s     = sv;
        e.name = name; e.db = edb; e.rs = ers; e.fl = efl; e.chg = echg;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // n cycles with no pulses expected and a constant debounced level.
    task automatic quiet(input string name, input int n, input logic rv,
                         input logic [3:0] sv, input logic [3:0] edb);
        for (int k = 0; k < n; k++) step(name, rv, sv, edb, 4'b0000, 4'b0000, 1'b0);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (s_db !== e.db || rise !== e.rs || fall !== e.fl || changed !== e.chg) begin
                    errors++;
                    $display("FAIL %s @%0t: got s_db=%b rise=%b fall=%b changed=%b, expected s_db=%b rise=%b fall=%b changed=%b",
                             e.name, $time, s_db, rise, fall, changed, e.db, e.rs, e.fl, e.chg);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s     = 4'b0000;

        // 1: reset for 3 cycles, then 20 quiet cycles.
        quiet("reset", 3, 1'b1, 4'b0000, 4'b0000);
        quiet("post_reset", 20, 1'b0, 4'b0000, 4'b0000);

        // 2: single step on bit 0, flip at edge 6, pulse lasts one cycle.
        quiet("step_wait", 5, 1'b0, 4'b0001, 4'b0000);
        step("step_flip", 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        quiet("step_hold", 4, 1'b0, 4'b0001, 4'b0001);

        // 3: bounce on bit 1 (2 cycles per level), then hold high.
        for (int b = 0; b < 2; b++) begin
            quiet("bounce_hi", 2, 1'b0, 4'b0011, 4'b0001);
            quiet("bounce_lo", 2, 1'b0, 4'b0001, 4'b0001);
        end
        quiet("bounce_final", 5, 1'b0, 4'b0011, 4'b0001);
        step("bounce_flip", 1'b0, 4'b0011, 4'b0011, 4'b0010, 4'b0000, 1'b1);
        quiet("bounce_hold", 3, 1'b0, 4'b0011, 4'b0011);

        // 4: 3-cycle glitch on bit 2 must never reach the output.
        quiet("glitch_hi", 3, 1'b0, 4'b0111, 4'b0011);
        quiet("glitch_lo", 10, 1'b0, 4'b0011, 4'b0011);

        // Return bit 1 low so the next scenario starts from 0001.
        quiet("fall_wait", 5, 1'b0, 4'b0001, 4'b0011);
        step("fall_flip", 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 1'b1);
        quiet("fall_hold", 3, 1'b0, 4'b0001, 4'b0001);

        // 5: simultaneous change 0001 -> 1110.
        quiet("simul_wait", 5, 1'b0, 4'b1110, 4'b0001);
        step("simul_flip", 1'b0, 4'b1110, 4'b1110, 4'b1110, 4'b0001, 1'b1);
        quiet("simul_hold", 3, 1'b0, 4'b1110, 4'b1110);

        // Clear everything before the reset-mid-count scenario.
        quiet("reset2", 2, 1'b1, 4'b0000, 4'b0000);
        quiet("reset2_idle", 8, 1'b0, 4'b0000, 4'b0000);

        // 6: raise bit 3, reset at edge 4, count restarts after release.
        quiet("midcnt_run", 3, 1'b0, 4'b1000, 4'b0000);
        quiet("midcnt_reset", 1, 1'b1, 4'b1000, 4'b0000);
        quiet("midcnt_wait", 5, 1'b0, 4'b1000, 4'b0000);
        step("midcnt_flip", 1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1);
        quiet("midcnt_hold", 3, 1'b0, 4'b1000, 4'b1000);

        // Let the monitor drain the queue.
        repeat (2) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_switch_debounce
`default_nettype wire
